coco_muldiv: RTL and testbench
==============================

// Module: coco_muldiv
// PURPOSE
//  Iterative 32-bit multiply/divide unit with HI/LO registers for the multicycle MIPS core.
//  Sits directly downstream of the main controller's MulDiv state.
//  Executes MULT/MULTU/DIV/DIVU, MTHI/MTLO and MFHI/MFLO.
//  Handshakes with the controller over MulDivStart/MulDivReady.
// PARAMETERS
//  WIDTH  32  operand/HI/LO width; iteration count = WIDTH (only 32 is verified)
// PORTS
//  Clk      in   1      system clock, rising edge
//  Reset_n  in   1      asynchronous, active-low reset
//  Start    in   1      level request, from MulDivStart; held high until Ready seen
//  MorD     in   1      1 = multiply, 0 = divide (sampled with Start)
//  HorL     in   1      1 = HI, 0 = LO; selects the We target and the Out source
//  Sign     in   1      1 = UNSIGNED op (MULTU/DIVU), 0 = signed (MULT/DIV); polarity fixed by controller
//  We       in   1      write A into HI/LO (MTHI/MTLO)
//  A        in   WIDTH  rs operand (multiplicand/dividend, MT data)
//  B        in   WIDTH  rt operand (multiplier/divisor)
//  Ready    out  1      operation complete / unit free
//  Busy     out  1      iteration in progress
//  Out      out  WIDTH  HorL ? HI : LO, combinational (MFHI/MFLO path)
// BEHAVIOUR
//  Reset (async, Reset_n=0): state=IDLE, HI=LO=0, counter=0, operand regs=0; Busy=0.
//    Ready=1 while Start=0.
//  FSM states: IDLE, BUSY, DONE.
//  IDLE:
//   - Start=1 at a clock edge: latch MorD, Sign, and |A|,|B| plus input signs
//     (magnitudes only when Sign=0). Counter=0. Go to BUSY.
//   - We=1 and Start=0: at the edge, HI<=A if HorL else LO<=A. Stay in IDLE.
//   - Start=1 and We=1 together: Start wins; the write is dropped.
//  BUSY: one radix-2 step per cycle, for exactly WIDTH cycles.
//   - Multiply: shift-add into a 2*WIDTH product.
//   - Divide: restoring; quotient/remainder regs.
//   - At the edge ending the WIDTH-th BUSY cycle: HI/LO are written with sign-corrected results and FSM goes to DONE.
//  DONE: one cycle; Start is ignored (still high from the controller). Then IDLE.
//  Ready = (state==DONE) | (state==IDLE & ~Start).
//   - Latency: first Ready=1 with Start high is exactly WIDTH cycles after the accepting edge.
//   - Start must drop before a new op is issued; the controller guarantees this via Fetch.
//  Busy = (state==BUSY). We during BUSY/DONE is ignored.
//  HI/LO never change outside the completion edge and We writes.
//  Result rules:
//   - MULT/MULTU: {HI,LO} = full 64-bit product.
//     Signed: the product is negated when signA^signB.
//   - DIV/DIVU: LO = quotient truncated toward zero; HI = remainder.
//     Remainder takes the dividend's sign.
//   - Divide by zero (any sign): LO = 32'hFFFFFFFF, HI = A unmodified.
//   - Signed 0x80000000 / -1: LO = 0x80000000, HI = 0 (wraps; no trap).
//  Out always tracks the current HI/LO and HorL, including during BUSY (old values).
//  Reset mid-op: the operation is abandoned, HI/LO=0, state IDLE immediately.
// TESTING
//  1) Reset=0 mid-random traffic -> HI=LO=0, Busy=0, Ready=1, Out=0.
//  2) MULT A=7, B=-3 (Sign=0): Start held -> Ready rises exactly 32 cycles after the accept edge.
//     Then HI=FFFFFFFF, LO=FFFFFFEB.
//  3) MULTU A=B=FFFFFFFF (Sign=1) -> HI=FFFFFFFE, LO=00000001.
//     Also MULT with the same operands -> HI=0, LO=1.
//  4) DIV A=-7, B=2 -> LO=FFFFFFFD, HI=FFFFFFFF.
//     DIVU A=7, B=0 -> LO=FFFFFFFF, HI=7.
//     DIV 80000000/FFFFFFFF -> LO=80000000, HI=0.
//  5) MTHI A=12345678 (HorL=1), then MTLO A=9 -> Out=12345678 with HorL=1, Out=9 with HorL=0.
//     We pulsed during BUSY -> HI/LO unchanged.
//  6) Reset_n pulsed at BUSY cycle 10 -> IDLE, HI=LO=0.
//     A following MULT 3*4 completes normally: LO=12, HI=0.

Source files
------------

// File: rtl/coco_muldiv.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers.
// One step per cycle for WIDTH cycles; operands are processed as magnitudes and sign-corrected at completion.
module coco_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             MorD,
  input  logic             HorL,
  input  logic             Sign,
  input  logic             We,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Ready,
  output logic             Busy,
  output logic [WIDTH-1:0] Out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, stateNxt;
  logic [WIDTH-1:0]   hi, lo, opA, opB;
  logic [2*WIDTH-1:0] acc, accNxt, res64;
  logic [CW-1:0]      cnt;
  logic               isMul, signA, signB;
  logic               lastStep, neg, bZero;
  logic               aNeg, bNeg;
  logic [WIDTH-1:0]   aMag, bMag, quo, rem, divLo, divHi, aOrig;
  logic [WIDTH:0]     mulSum, divSh, divDiff;

  // Magnitudes at accept; Sign=1 means unsigned.
  assign aNeg = ~Sign & A[WIDTH-1];
  assign bNeg = ~Sign & B[WIDTH-1];
  assign aMag = aNeg ? -A : A;
  assign bMag = bNeg ? -B : B;

  assign lastStep = (state == BUSY) && (cnt == CW'(WIDTH-1));

  // acc holds {product-high, multiplier} for multiply, {remainder, dividend/quotient} for divide.
  always_comb begin
    mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opA : {WIDTH{1'b0}})};
    divSh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    divDiff = divSh - {1'b0, opB};
    if (isMul)
      accNxt = {mulSum, acc[WIDTH-1:1]};
    else if (divDiff[WIDTH])
      accNxt = {divSh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      accNxt = {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    neg   = signA ^ signB;
    bZero = (opB == '0);
    res64 = neg ? -accNxt : accNxt;
    quo   = accNxt[WIDTH-1:0];
    rem   = accNxt[2*WIDTH-1:WIDTH];
    aOrig = signA ? -opA : opA;
    divLo = bZero ? {WIDTH{1'b1}} : (neg ? -quo : quo);
    divHi = bZero ? aOrig : (signA ? -rem : rem);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (Start) stateNxt = BUSY;
      BUSY:    if (lastStep) stateNxt = DONE;
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hi    <= '0;
      lo    <= '0;
      opA   <= '0;
      opB   <= '0;
      acc   <= '0;
      cnt   <= '0;
      isMul <= 1'b0;
      signA <= 1'b0;
      signB <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            isMul <= MorD;
            signA <= aNeg;
            signB <= bNeg;
            opA   <= aMag;
            opB   <= bMag;
            acc   <= MorD ? {{WIDTH{1'b0}}, bMag} : {{WIDTH{1'b0}}, aMag};
            cnt   <= '0;
          end else if (We) begin
            if (HorL) hi <= A;
            else      lo <= A;
          end
        end
        BUSY: begin
          acc <= accNxt;
          cnt <= cnt + CW'(1);
          if (lastStep) begin
            hi <= isMul ? res64[2*WIDTH-1:WIDTH] : divHi;
            lo <= isMul ? res64[WIDTH-1:0]       : divLo;
          end
        end
        default: ;
      endcase
    end
  end

  assign Ready = (state == DONE) | ((state == IDLE) & ~Start);
  assign Busy  = (state == BUSY);
  assign Out   = HorL ? hi : lo;

endmodule

// File: tb/tb_coco_muldiv.sv
// Directed-vector bench for coco_muldiv: latency, MULT/DIV result rules, MT writes, reset mid-op.
module tb_coco_muldiv;

  logic        Clk, Reset_n, Start, MorD, HorL, Sign, We;
  logic [31:0] A, B, Out;
  logic        Ready, Busy;
  int          nChecks = 0;
  int          nErrors = 0;

  coco_muldiv #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .MorD(MorD), .HorL(HorL),
    .Sign(Sign), .We(We), .A(A), .B(B), .Ready(Ready), .Busy(Busy), .Out(Out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic readHL(input logic horl, output logic [31:0] v);
    HorL = horl;
    #1 v = Out;
  endtask

  task automatic mt(input logic horl, input logic [31:0] val);
    @(negedge Clk);
    We = 1'b1; HorL = horl; A = val;
    @(posedge Clk);
    #1 We = 1'b0;
  endtask

  task automatic startOp(input logic morD, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    Start = 1'b1; MorD = morD; Sign = sgn; A = a; B = b;
    @(posedge Clk);
    #1;
  endtask

  task automatic waitReady(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge Clk);
      #1;
      if (Ready) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic finishOp(input string tag, input logic [31:0] expHi, input logic [31:0] expLo);
    logic [31:0] v;
    Start = 1'b0;
    @(posedge Clk);
    #1;
    chk({tag, "_busy_idle"}, 32'(Busy), 32'd0);
    chk({tag, "_ready_idle"}, 32'(Ready), 32'd1);
    readHL(1'b1, v); chk({tag, "_hi"}, v, expHi);
    readHL(1'b0, v); chk({tag, "_lo"}, v, expLo);
  endtask

  task automatic runOp(input string tag, input logic morD, input logic sgn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expHi, input logic [31:0] expLo);
    int n;
    startOp(morD, sgn, a, b);
    chk({tag, "_busy"}, 32'(Busy), 32'd1);
    chk({tag, "_ready_busy"}, 32'(Ready), 32'd0);
    waitReady(n);
    chk({tag, "_latency"}, 32'(n), 32'd32);
    finishOp(tag, expHi, expLo);
  endtask

  initial begin
    logic [31:0] v;
    int n;
    Reset_n = 1'b0; Start = 1'b0; MorD = 1'b0; HorL = 1'b0; Sign = 1'b0; We = 1'b0;
    A = '0; B = '0;
    #2;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_ready", 32'(Ready), 32'd1);
    readHL(1'b1, v); chk("rst_hi", v, 32'h0);
    readHL(1'b0, v); chk("rst_lo", v, 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // MTHI/MTLO and Out selection
    mt(1'b1, 32'h12345678);
    mt(1'b0, 32'h00000009);
    readHL(1'b1, v); chk("mthi", v, 32'h12345678);
    readHL(1'b0, v); chk("mtlo", v, 32'h00000009);

    // We during BUSY is ignored; Out shows the old HI/LO while iterating
    startOp(1'b1, 1'b0, 32'd2, 32'd5);
    @(negedge Clk);
    We = 1'b1; HorL = 1'b1; A = 32'hDEADBEEF;
    @(posedge Clk);
    #1 We = 1'b0;
    readHL(1'b1, v); chk("we_busy_hi", v, 32'h12345678);
    readHL(1'b0, v); chk("we_busy_lo", v, 32'h00000009);
    waitReady(n);
    chk("we_busy_latency", 32'(n), 32'd31);
    finishOp("mult2x5", 32'h0, 32'd10);

    runOp("mult7xm3",   1'b1, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    runOp("multu_ff",   1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    runOp("mult_ff",    1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
    runOp("div_m7_2",   1'b0, 1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("div_7_m2",   1'b0, 1'b0, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    runOp("divu_7_0",   1'b0, 1'b1, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF);
    runOp("div_m5_0",   1'b0, 1'b0, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);
    runOp("div_ovf",    1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    runOp("divu_big",   1'b0, 1'b1, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF);

    // Reset asserted around the 10th BUSY cycle with non-zero HI/LO
    startOp(1'b1, 1'b0, 32'd5, 32'd6);
    repeat (9) @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    Start = 1'b0;
    #1;
    chk("midrst_busy", 32'(Busy), 32'd0);
    chk("midrst_ready", 32'(Ready), 32'd1);
    readHL(1'b1, v); chk("midrst_hi", v, 32'h0);
    readHL(1'b0, v); chk("midrst_lo", v, 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;

    runOp("mult3x4", 1'b1, 1'b0, 32'd3, 32'd4, 32'h0, 32'd12);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
